// File: rtl/ioctl_bios_loader.sv
// ioctl download receiver: queues HPS image bytes and writes them into SRAM at the BIOS window.
// Define IOCTL_BIOS_CHECKSUM_EN to add a mod-256 checksum output of all bytes written.
module ioctl_bios_loader #(
  parameter int                ADDR_W     = 21,
  parameter int                BIOS_INDEX = 0,
  parameter logic [ADDR_W-1:0] BIOS_BASE  = 21'h1F0000,
  parameter int                BIOS_SIZE  = 65536,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic              mem_ack,
  output logic              loading,
  output logic              bios_loaded,
  output logic              overflow
`ifdef IOCTL_BIOS_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  // state | meaning
  // IDLE  | waiting for a rising edge of sel
  // RECV  | download active, bytes pushed into the FIFO
  // DRAIN | download ended, FIFO and outstanding write still emptying
  // DONE  | image complete, flags updated on the way back to IDLE

  localparam int OFF_W   = $clog2(BIOS_SIZE);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = OFF_W + 8;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DRAIN, ST_DONE} state_t;

  state_t state, state_next;

  logic               sel, sel_q, sel_rise;
  logic               enter_recv, finish;
  logic               push_req, in_range, fifo_full, push, drop, pop;
  logic [CNT_W-1:0]   fifo_cnt, cnt_next;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] pop_entry;
  logic               wait_next;
  logic               index_unused;

  assign index_unused = ^ioctl_index[15:6];

  assign sel      = ioctl_download && (ioctl_index[5:0] == 6'(BIOS_INDEX));
  assign sel_rise = sel && !sel_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    enter_recv = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_rise) begin
          state_next = ST_RECV;
          enter_recv = 1'b1;
        end
      end
      ST_RECV:  if (!sel) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_cnt == '0 && !mem_req) state_next = ST_DONE;
      ST_DONE: begin
        state_next = ST_IDLE;
        finish     = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strobes still count on the cycle sel falls, since state is RECV until the next edge.
  assign push_req  = (state == ST_RECV) && ioctl_wr;
  assign in_range  = 32'(ioctl_addr) < 32'(BIOS_SIZE);
  assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push      = push_req && in_range && !fifo_full;
  assign drop      = push_req && !push;
  assign pop       = !mem_req && (fifo_cnt != '0) && !enter_recv;
  assign pop_entry = fifo_mem[rd_ptr];

  always_comb begin
    cnt_next = fifo_cnt;
    if (enter_recv)       cnt_next = '0;
    else if (push && !pop) cnt_next = fifo_cnt + CNT_W'(1);
    else if (pop && !push) cnt_next = fifo_cnt - CNT_W'(1);
  end

  assign wait_next = ((state_next == ST_RECV) || (state_next == ST_DRAIN)) &&
                     (cnt_next >= CNT_W'(FIFO_DEPTH - 1));

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= {ioctl_addr[OFF_W-1:0], ioctl_dout};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_q       <= 1'b0;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ioctl_wait  <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_dout    <= '0;
      loading     <= 1'b0;
      bios_loaded <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sel_q      <= sel;
      fifo_cnt   <= cnt_next;
      ioctl_wait <= wait_next;
      if (enter_recv) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        loading     <= 1'b1;
        bios_loaded <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (drop) overflow <= 1'b1;
      end
      if (finish) begin
        loading     <= 1'b0;
        bios_loaded <= 1'b1;
      end
      // One write in flight; the next pop waits for the cycle after mem_ack.
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
      end else if (pop) begin
        mem_req  <= 1'b1;
        mem_addr <= BIOS_BASE + ADDR_W'(pop_entry[ENTRY_W-1:8]);
        mem_dout <= pop_entry[7:0];
      end
    end
  end

`ifdef IOCTL_BIOS_CHECKSUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                checksum <= '0;
    else if (enter_recv)         checksum <= '0;
    else if (mem_req && mem_ack) checksum <= checksum + mem_dout;
  end
`endif

endmodule

// File: tb/tb_ioctl_bios_loader.sv
// Directed bench for ioctl_bios_loader: SRAM responder with programmable ack delay and write log.
module tb_ioctl_bios_loader;
  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic [15:0] ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_ack;
  logic        loading;
  logic        bios_loaded;
  logic        overflow;
`ifdef IOCTL_BIOS_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int checks = 0;
  int errors = 0;
  int ack_delay = 1;
  logic [20:0] log_addr[$];
  logic [7:0]  log_data[$];
  time last_ack_t = 0;

  ioctl_bios_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_ack(mem_ack),
    .loading(loading), .bios_loaded(bios_loaded), .overflow(overflow)
`ifdef IOCTL_BIOS_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial begin
    clk_sys = 0;
    forever #5 clk_sys = ~clk_sys;
  end

  // SRAM model: acks after ack_delay idle cycles of mem_req, logs each acked write.
  initial begin
    int age;
    age = 0;
    mem_ack = 0;
    forever begin
      @(negedge clk_sys);
      mem_ack = 0;
      if (mem_req && reset_n) begin
        if (age >= ack_delay) begin
          mem_ack = 1;
          log_addr.push_back(mem_addr);
          log_data.push_back(mem_dout);
          last_ack_t = $time;
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic begin_download(input logic [15:0] idx);
    ioctl_index = idx;
    ioctl_download = 1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_download();
    ioctl_download = 0;
    @(negedge clk_sys);
  endtask

  task automatic send_one(input logic [24:0] off, input logic [7:0] d);
    int g;
    g = 0;
    while (ioctl_wait && g < 100) begin
      @(negedge clk_sys);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_wait_timeout: ioctl_wait=%0b, required 0", ioctl_wait);
    end
    ioctl_wr = 1; ioctl_addr = off; ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 0;
    @(negedge clk_sys);
  endtask

  // Streams n bytes at offsets 0..n-1 with data d0+i, one per cycle while ioctl_wait is low.
  task automatic stream(input int n, input logic [7:0] d0, output int first_wait);
    int i;
    int g;
    i = 0; g = 0; first_wait = -1;
    while (i < n && g < 2000) begin
      if (ioctl_wait) begin
        ioctl_wr = 0;
        if (first_wait < 0) first_wait = i;
      end else begin
        ioctl_wr = 1; ioctl_addr = 25'(i); ioctl_dout = d0 + 8'(i);
        i++;
      end
      @(negedge clk_sys);
      g++;
    end
    ioctl_wr = 0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL stream_complete: sent %0d bytes, required %0d", i, n);
    end
  endtask

  task automatic wait_loaded(output time t_rise);
    int g;
    g = 0;
    while (!bios_loaded && g < 500) begin
      @(negedge clk_sys);
      g++;
    end
    t_rise = $time;
    checks++;
    if (bios_loaded !== 1'b1) begin
      errors++;
      $display("FAIL bios_loaded_timeout: bios_loaded=%0b after %0d cycles, required 1", bios_loaded, g);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({ioctl_wait, mem_req, mem_addr, mem_dout, loading, bios_loaded, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_held: outputs=%h, required 0",
               {ioctl_wait, mem_req, mem_addr, mem_dout, loading, bios_loaded, overflow});
    end
    reset_n = 1;
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({ioctl_wait, mem_req, mem_addr, mem_dout, loading, bios_loaded, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_released: outputs=%h, required 0",
               {ioctl_wait, mem_req, mem_addr, mem_dout, loading, bios_loaded, overflow});
    end
  endtask

  task automatic test_index_mismatch(input logic [15:0] idx, input logic exp_loaded,
                                     input logic exp_ovf);
    logic saw;
    saw = 0;
    log_addr.delete(); log_data.delete();
    begin_download(idx);
    for (int i = 0; i < 8; i++) begin
      ioctl_wr = 1; ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1);
      @(negedge clk_sys);
      if (mem_req || loading || ioctl_wait) saw = 1;
      ioctl_wr = 0;
      @(negedge clk_sys);
      if (mem_req || loading || ioctl_wait) saw = 1;
    end
    end_download();
    repeat (5) @(negedge clk_sys);
    checks++;
    if (saw !== 1'b0 || log_addr.size() != 0) begin
      errors++;
      $display("FAIL mismatch_activity: activity=%0b writes=%0d, required 0 and 0", saw, log_addr.size());
    end
    checks++;
    if (loading !== 1'b0 || bios_loaded !== exp_loaded || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL mismatch_flags: loading=%0b bios_loaded=%0b overflow=%0b, required 0 %0b %0b",
               loading, bios_loaded, overflow, exp_loaded, exp_ovf);
    end
  endtask

  task automatic test_latency();
    time t;
    log_addr.delete(); log_data.delete();
    ack_delay = 1;
    begin_download(16'h0000);
    ioctl_wr = 1; ioctl_addr = 25'd5; ioctl_dout = 8'h5A;
    @(negedge clk_sys);
    ioctl_wr = 0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL latency_cycle1: mem_req=%0b, required 0", mem_req);
    end
    @(negedge clk_sys);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 21'h1F0005 || mem_dout !== 8'h5A) begin
      errors++;
      $display("FAIL latency_cycle2: mem_req=%0b addr=%h data=%h, required 1 1f0005 5a",
               mem_req, mem_addr, mem_dout);
    end
    end_download();
    wait_loaded(t);
    checks++;
    if (log_addr.size() != 1) begin
      errors++;
      $display("FAIL latency_writes: got %0d writes, required 1", log_addr.size());
    end
  endtask

  task automatic test_basic();
    int fw;
    time t;
    logic [20:0] ea;
    log_addr.delete(); log_data.delete();
    ack_delay = 1;
    begin_download(16'h0000);
    checks++;
    if (loading !== 1'b1 || bios_loaded !== 1'b0) begin
      errors++;
      $display("FAIL basic_start: loading=%0b bios_loaded=%0b, required 1 0", loading, bios_loaded);
    end
    stream(16, 8'h00, fw);
    end_download();
    checks++;
    if (loading !== 1'b1) begin
      errors++;
      $display("FAIL basic_loading_drain: loading=%0b, required 1", loading);
    end
    wait_loaded(t);
    checks++;
    if (t - last_ack_t != 30) begin
      errors++;
      $display("FAIL basic_done_timing: bios_loaded %0d after last ack, required 30", t - last_ack_t);
    end
    checks++;
    if (loading !== 1'b0 || overflow !== 1'b0 || ioctl_wait !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_flags: loading=%0b overflow=%0b wait=%0b req=%0b, required 0 0 0 0",
               loading, overflow, ioctl_wait, mem_req);
    end
    checks++;
    if (log_addr.size() != 16) begin
      errors++;
      $display("FAIL basic_write_count: got %0d, required 16", log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 16; i++) begin
      ea = 21'h1F0000 + 21'(i);
      checks++;
      if (log_addr[i] !== ea || log_data[i] !== 8'(i)) begin
        errors++;
        $display("FAIL basic_write_%0d: addr=%h data=%h, required %h %h", i, log_addr[i], log_data[i], ea, 8'(i));
      end
    end
  endtask

  task automatic test_back_pressure();
    int fw;
    time t;
    logic [20:0] ea;
    log_addr.delete(); log_data.delete();
    ack_delay = 10;
    begin_download(16'h0000);
    stream(32, 8'h80, fw);
    checks++;
    if (fw != 4) begin
      errors++;
      $display("FAIL bp_wait_point: ioctl_wait first seen after %0d strobes, required 4", fw);
    end
    end_download();
    wait_loaded(t);
    checks++;
    if (overflow !== 1'b0 || log_addr.size() != 32) begin
      errors++;
      $display("FAIL bp_totals: overflow=%0b writes=%0d, required 0 32", overflow, log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 32; i++) begin
      ea = 21'h1F0000 + 21'(i);
      checks++;
      if (log_addr[i] !== ea || log_data[i] !== 8'h80 + 8'(i)) begin
        errors++;
        $display("FAIL bp_write_%0d: addr=%h data=%h, required %h %h", i, log_addr[i], log_data[i], ea, 8'h80 + 8'(i));
      end
    end
    ack_delay = 1;
  endtask

  task automatic test_overflow();
    time t;
    log_addr.delete(); log_data.delete();
    begin_download(16'h0000);
    send_one(25'd65535, 8'hAA);
    send_one(25'd65536, 8'hBB);
    end_download();
    wait_loaded(t);
    checks++;
    if (log_addr.size() != 1) begin
      errors++;
      $display("FAIL ovf_write_count: got %0d, required 1", log_addr.size());
    end else begin
      checks++;
      if (log_addr[0] !== 21'h1FFFFF || log_data[0] !== 8'hAA) begin
        errors++;
        $display("FAIL ovf_write: addr=%h data=%h, required 1fffff aa", log_addr[0], log_data[0]);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: overflow=%0b, required 1", overflow);
    end
  endtask

  task automatic test_reload_clears();
    time t;
    log_addr.delete(); log_data.delete();
    begin_download(16'h0000);
    checks++;
    if (overflow !== 1'b0 || bios_loaded !== 1'b0 || loading !== 1'b1) begin
      errors++;
      $display("FAIL reload_entry: overflow=%0b bios_loaded=%0b loading=%0b, required 0 0 1",
               overflow, bios_loaded, loading);
    end
    send_one(25'd0, 8'h33);
    end_download();
    wait_loaded(t);
    checks++;
    if (log_data.size() != 1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reload_end: writes=%0d overflow=%0b, required 1 0", log_data.size(), overflow);
    end
  endtask

  task automatic test_reset_mid_load();
    int fw;
    time t;
    logic [20:0] ea;
    begin_download(16'h0000);
    stream(5, 8'h40, fw);
    reset_n = 0;
    #1;
    checks++;
    if ({ioctl_wait, mem_req, mem_addr, mem_dout, loading, bios_loaded, overflow} !== '0) begin
      errors++;
      $display("FAIL midreset_async: outputs=%h, required 0",
               {ioctl_wait, mem_req, mem_addr, mem_dout, loading, bios_loaded, overflow});
    end
    ioctl_download = 0;
    @(negedge clk_sys);
    reset_n = 1;
    repeat (5) @(negedge clk_sys);
    checks++;
    if (bios_loaded !== 1'b0 || loading !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after: bios_loaded=%0b loading=%0b req=%0b, required 0 0 0",
               bios_loaded, loading, mem_req);
    end
    log_addr.delete(); log_data.delete();
    begin_download(16'h0000);
    stream(10, 8'h60, fw);
    end_download();
    wait_loaded(t);
    checks++;
    if (log_addr.size() != 10) begin
      errors++;
      $display("FAIL midreset_write_count: got %0d, required 10", log_addr.size());
    end
    for (int i = 0; i < log_addr.size() && i < 10; i++) begin
      ea = 21'h1F0000 + 21'(i);
      checks++;
      if (log_addr[i] !== ea || log_data[i] !== 8'h60 + 8'(i)) begin
        errors++;
        $display("FAIL midreset_write_%0d: addr=%h data=%h, required %h %h", i, log_addr[i], log_data[i], ea, 8'h60 + 8'(i));
      end
    end
  endtask

`ifdef IOCTL_BIOS_CHECKSUM_EN
  task automatic test_checksum();
    time t;
    begin_download(16'h0000);
    send_one(25'd0, 8'h01);
    send_one(25'd1, 8'hFF);
    send_one(25'd2, 8'h10);
    end_download();
    wait_loaded(t);
    checks++;
    if (checksum !== 8'h10) begin
      errors++;
      $display("FAIL checksum: got %h, required 10", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_index_mismatch(16'h0001, 1'b0, 1'b0);
    test_latency();
    test_basic();
    test_back_pressure();
    test_overflow();
    test_index_mismatch(16'h0003, 1'b1, 1'b1);
    test_reload_clears();
    test_reset_mid_load();
`ifdef IOCTL_BIOS_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
